fft_reorder: RTL and testbench

Bit-reversal reorder buffer at the output end of the 128-point SDF FFT pipeline. It reads the final stage's bit-reversed sample stream and writes natural-order frames (X[0]..X[N-1]) into a ping-pong pair of register banks. Sample width is unchanged. It sits between the last butterfly stage and downstream consumers, and passes frame markers (first/last) with the data.

---
 rtl/fft_reorder.sv | 107 ++++++++++
 tb/tb_fft_reorder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder.sv
// Bit-reversal reorder buffer for the 128-point SDF FFT output: bit-reversed
// input stream in, natural-order frames out, through a ping-pong pair of banks.
module fft_reorder #(
  parameter int BW    = 16,
  parameter int N     = 128,
  parameter int LOG2N = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [BW-1:0]    In_Real,
  input  logic [BW-1:0]    In_Imag,
  output logic [BW-1:0]    Out_Real,
  output logic [BW-1:0]    Out_Imag,
  output logic             Out_Valid,
  output logic [LOG2N-1:0] Out_Idx,
  output logic             Out_Sof,
  output logic             Out_Last
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t           state;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] wr_addr;
  logic             wr_bank;
  logic [LOG2N-1:0] rd_cnt;
  logic             rd_bank;
  logic             frame_done;
  logic [2*BW-1:0]  rd_data;

  // Both banks in one array; the top address bit selects the bank.
  logic [2*BW-1:0]  mem [2*N];

  for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
    assign wr_addr[gi] = wr_cnt[LOG2N-1-gi];
  end

  assign frame_done = valid && (wr_cnt == LAST);
  assign rd_data    = mem[{rd_bank, rd_cnt}];

  always_ff @(posedge clk) begin
    if (reset_n && valid) begin
      mem[{wr_bank, wr_addr}] <= {In_Real, In_Imag};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (valid) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_cnt == LAST) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      Out_Real  <= '0;
      Out_Imag  <= '0;
      Out_Idx   <= '0;
      Out_Valid <= 1'b0;
      Out_Sof   <= 1'b0;
      Out_Last  <= 1'b0;
    end else begin
      Out_Valid <= 1'b0;
      Out_Sof   <= 1'b0;
      Out_Last  <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_done) begin
            state   <= READ;
            rd_bank <= wr_bank;
            rd_cnt  <= '0;
          end
        end
        READ: begin
          Out_Valid <= 1'b1;
          Out_Real  <= rd_data[2*BW-1:BW];
          Out_Imag  <= rd_data[BW-1:0];
          Out_Idx   <= rd_cnt;
          Out_Sof   <= (rd_cnt == '0);
          Out_Last  <= (rd_cnt == LAST);
          // A new full frame always wins, keeping back-to-back output gapless.
          if (frame_done) begin
            rd_bank <= wr_bank;
            rd_cnt  <= '0;
          end else if (rd_cnt == LAST) begin
            state  <= IDLE;
            rd_cnt <= '0;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// Self-checking bench for fft_reorder: directed steps with random data, checked
// against a queue model of completed natural-order frames.
module tb_fft_reorder;
  localparam int BW    = 16;
  localparam int N     = 128;
  localparam int LOG2N = 7;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             valid = 1'b0;
  logic [BW-1:0]    in_real = '0;
  logic [BW-1:0]    in_imag = '0;
  logic [BW-1:0]    out_real;
  logic [BW-1:0]    out_imag;
  logic             out_valid;
  logic [LOG2N-1:0] out_idx;
  logic             out_sof;
  logic             out_last;

  fft_reorder #(.BW(BW), .N(N), .LOG2N(LOG2N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .valid    (valid),
    .In_Real  (in_real),
    .In_Imag  (in_imag),
    .Out_Real (out_real),
    .Out_Imag (out_imag),
    .Out_Valid(out_valid),
    .Out_Idx  (out_idx),
    .Out_Sof  (out_sof),
    .Out_Last (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] re;
    logic [BW-1:0] im;
    int            idx;
  } smp_t;

  int            tests = 0;
  int            fails = 0;
  smp_t          q[$];
  logic [BW-1:0] pend_re[N];
  logic [BW-1:0] pend_im[N];
  int            wcnt = 0;
  logic [BW-1:0] last_re = '0;
  logic [BW-1:0] last_im = '0;
  int            last_idx = 0;
  bit            seen_out = 1'b0;
  int            frames_out = 0;

  function automatic int bitrev(input int v);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) begin
      if (v[b]) r |= (1 << (LOG2N - 1 - b));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive input, check outputs after the edge, then update the model.
  task automatic step(input bit v, input logic [BW-1:0] re, input logic [BW-1:0] im);
    smp_t e;
    smp_t f;
    valid   = v;
    in_real = re;
    in_imag = im;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("valid", 32'(out_valid), 32'd1);
      chk("real", 32'(out_real), 32'(e.re));
      chk("imag", 32'(out_imag), 32'(e.im));
      chk("idx", 32'(out_idx), 32'(e.idx));
      chk("sof", 32'(out_sof), (e.idx == 0) ? 32'd1 : 32'd0);
      chk("last", 32'(out_last), (e.idx == N - 1) ? 32'd1 : 32'd0);
      last_re  = e.re;
      last_im  = e.im;
      last_idx = e.idx;
      seen_out = 1'b1;
      if (e.idx == N - 1) begin
        frames_out++;
        $display("[TB] frame %0d emitted, X[0..%0d]", frames_out, N - 1);
      end
    end else begin
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("hold_real", 32'(out_real), 32'(last_re));
      chk("hold_imag", 32'(out_imag), 32'(last_im));
      chk("hold_idx", 32'(out_idx), 32'(last_idx));
      chk("idle_sof", 32'(out_sof), 32'd0);
      chk("idle_last", 32'(out_last), 32'd0);
    end
    if (v) begin
      pend_re[bitrev(wcnt)] = re;
      pend_im[bitrev(wcnt)] = im;
      wcnt++;
      if (wcnt == N) begin
        for (int k = 0; k < N; k++) begin
          f.re = pend_re[k];
          f.im = pend_im[k];
          f.idx = k;
          q.push_back(f);
        end
        wcnt = 0;
      end
    end
  endtask

  // Reset for one edge with live input, which must be ignored.
  task automatic do_reset();
    reset_n = 1'b0;
    valid   = 1'b1;
    in_real = BW'($urandom);
    in_imag = BW'($urandom);
    @(posedge clk);
    #1;
    chk("rst_real", 32'(out_real), 32'd0);
    chk("rst_imag", 32'(out_imag), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sof", 32'(out_sof), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    reset_n  = 1'b1;
    valid    = 1'b0;
    q.delete();
    wcnt     = 0;
    last_re  = '0;
    last_im  = '0;
    last_idx = 0;
    seen_out = 1'b0;
    $display("[TB] reset applied");
  endtask

  task automatic rand_frame(input bit gapped);
    for (int i = 0; i < N; i++) begin
      if (gapped) step(1'b0, BW'($urandom), BW'($urandom));
      step(1'b1, BW'($urandom), BW'($urandom));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < N + 4; i++) step(1'b0, '0, '0);
  endtask

  initial begin
    do_reset();
    do_reset();

    // Single frame: natural index in real, its negation in imag.
    for (int i = 0; i < N; i++) begin
      step(1'b1, BW'(bitrev(i)), BW'(-bitrev(i)));
    end
    drain();

    // Three back-to-back frames, real = f*128 + natural index.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) begin
        step(1'b1, BW'(f * N + bitrev(i)), BW'($urandom));
      end
    end
    drain();

    // Alternate-cycle input.
    rand_frame(1'b1);
    drain();

    // Reset while index 60 is on the output.
    rand_frame(1'b0);
    for (int i = 0; i < 3 * N; i++) begin
      if (seen_out && last_idx == 60) break;
      step(1'b0, '0, '0);
    end
    chk("reached_idx60", 32'(last_idx), 32'd60);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, '0, '0);
    rand_frame(1'b0);
    drain();

    // Reset mid-write: partial frame discarded.
    for (int i = 0; i < 50; i++) step(1'b1, BW'($urandom), BW'($urandom));
    do_reset();
    rand_frame(1'b0);
    drain();

    // Extremes alternating in arrival order.
    for (int i = 0; i < N; i++) begin
      step(1'b1, (i % 2 == 0) ? 16'h7FFF : 16'h8000, (i % 2 == 0) ? 16'h8000 : 16'h7FFF);
    end
    drain();

    // Random valid pattern across two frames.
    for (int i = 0; i < 4 * N; i++) begin
      step(1'($urandom_range(0, 1)), BW'($urandom), BW'($urandom));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
